// File: rtl/periph_rsp_pkg.sv
// Shared response types for periph_rsp_buffer and its response FIFO.
package periph_rsp_pkg;

   localparam int unsigned DATA_WIDTH         = 32;
   localparam int unsigned ID_WIDTH           = 5;
   localparam int unsigned PERIPH_RSP_LATENCY = 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      logic [ID_WIDTH-1:0]   id;
      logic                  opc;
   } periph_rsp_t;

endpackage

// File: rtl/periph_rsp_fifo.sv
// DEPTH-entry response FIFO with registered storage; data_o reads zero while empty.
module periph_rsp_fifo
   import periph_rsp_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  periph_rsp_t      data_i,
   input  logic             pop_i,
   output periph_rsp_t      data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   periph_rsp_t      mem_q [DEPTH];
   periph_rsp_t      mem_d [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign count_o = count_q;
   assign data_o  = empty_o ? '0 : mem_q[rptr_q];

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         mem_d[wptr_q] = data_i;
         wptr_d        = ptr_inc(wptr_q);
      end
      if (do_pop) begin
         rptr_d = ptr_inc(rptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/periph_rsp_buffer.sv
// Credit-based adapter from a backpressured initiator to the fixed-latency peripheral bus.
// Define PERIPH_RSP_BYPASS_EN to forward responses combinationally when the FIFO is empty.
module periph_rsp_buffer #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 5,
   parameter int unsigned DEPTH      = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   input  logic [ADDR_WIDTH-1:0]   add_i,
   input  logic                    wen_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [ID_WIDTH-1:0]     id_i,
   output logic                    gnt_o,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic [ID_WIDTH-1:0]     rsp_id_o,
   output logic                    rsp_opc_o,
   output logic                    slv_req_o,
   output logic [ADDR_WIDTH-1:0]   slv_add_o,
   output logic                    slv_wen_o,
   output logic [DATA_WIDTH/8-1:0] slv_be_o,
   output logic [DATA_WIDTH-1:0]   slv_wdata_o,
   output logic [ID_WIDTH-1:0]     slv_id_o,
   input  logic                    slv_gnt_i,
   input  logic                    slv_r_valid_i,
   input  logic [DATA_WIDTH-1:0]   slv_r_rdata_i,
   input  logic [ID_WIDTH-1:0]     slv_r_id_i,
   input  logic                    slv_r_opc_i,
   output logic                    err_o
);

   import periph_rsp_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("periph_rsp_buffer: DEPTH must be in 1..8");
   end
   if (DATA_WIDTH != periph_rsp_pkg::DATA_WIDTH || ID_WIDTH != periph_rsp_pkg::ID_WIDTH)
   begin : g_bad_width
      $error("periph_rsp_buffer: DATA_WIDTH/ID_WIDTH must match periph_rsp_pkg");
   end

   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic [CNT_W:0]   used;
   logic             credit_ok;
   logic             rsp_expected;
   logic             rsp_unexpected;
   logic             bypass;
   periph_rsp_t      slv_rsp;
   periph_rsp_t      fifo_rsp;
   periph_rsp_t      rsp_sel;

   // Credit uses registered occupancy only, keeping rsp_ready_i out of the gnt_o cone.
   assign used      = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(outstanding_q);
   assign credit_ok = (used < (CNT_W + 1)'(DEPTH));

   assign slv_req_o   = req_i & credit_ok;
   assign gnt_o       = slv_req_o & slv_gnt_i;
   assign slv_add_o   = add_i;
   assign slv_wen_o   = wen_i;
   assign slv_be_o    = be_i;
   assign slv_wdata_o = wdata_i;
   assign slv_id_o    = id_i;

   assign rsp_expected   = slv_r_valid_i & (outstanding_q != '0);
   assign rsp_unexpected = slv_r_valid_i & (outstanding_q == '0);

   always_comb begin
      slv_rsp       = '0;
      slv_rsp.rdata = slv_r_rdata_i;
      slv_rsp.id    = slv_r_id_i;
      slv_rsp.opc   = slv_r_opc_i;
   end

`ifdef PERIPH_RSP_BYPASS_EN
   assign bypass = rsp_expected & fifo_empty & rsp_ready_i;
`else
   assign bypass = 1'b0;
`endif

   assign fifo_push   = rsp_expected & ~bypass;
   assign fifo_pop    = ~fifo_empty & rsp_ready_i;
   assign rsp_valid_o = ~fifo_empty | bypass;
   assign rsp_sel     = bypass ? slv_rsp : fifo_rsp;
   assign rsp_rdata_o = rsp_sel.rdata;
   assign rsp_id_o    = rsp_sel.id;
   assign rsp_opc_o   = rsp_sel.opc;
   assign err_o       = err_q;

   always_comb begin
      outstanding_d = outstanding_q;
      case ({gnt_o, rsp_expected})
         2'b10:   outstanding_d = outstanding_q + 1'b1;
         2'b01:   outstanding_d = outstanding_q - 1'b1;
         default: outstanding_d = outstanding_q;
      endcase
      err_d = err_q | rsp_unexpected;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

   periph_rsp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push),
      .data_i  (slv_rsp),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rsp),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // The credit rule guarantees a free slot for every expected response.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(fifo_push && fifo_full));

endmodule

// File: tb/tb_periph_rsp_buffer.sv
// Directed bench for periph_rsp_buffer (DEPTH=2); bypass checks build with PERIPH_RSP_BYPASS_EN.
module tb_periph_rsp_buffer;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned IW    = 5;
   localparam int unsigned DEPTH = 2;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            req_i;
   logic [AW-1:0]   add_i;
   logic            wen_i;
   logic [DW/8-1:0] be_i;
   logic [DW-1:0]   wdata_i;
   logic [IW-1:0]   id_i;
   logic            gnt_o;
   logic            rsp_valid_o;
   logic            rsp_ready_i;
   logic [DW-1:0]   rsp_rdata_o;
   logic [IW-1:0]   rsp_id_o;
   logic            rsp_opc_o;
   logic            slv_req_o;
   logic [AW-1:0]   slv_add_o;
   logic            slv_wen_o;
   logic [DW/8-1:0] slv_be_o;
   logic [DW-1:0]   slv_wdata_o;
   logic [IW-1:0]   slv_id_o;
   logic            slv_gnt_i;
   logic            slv_r_valid_i;
   logic [DW-1:0]   slv_r_rdata_i;
   logic [IW-1:0]   slv_r_id_i;
   logic            slv_r_opc_i;
   logic            err_o;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   logic        auto_rsp;
   logic        rdata_mode;
   logic [31:0] fixed_rdata;

   always #5 clk_i = ~clk_i;

   periph_rsp_buffer #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .ID_WIDTH   (IW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_i         (req_i),
      .add_i         (add_i),
      .wen_i         (wen_i),
      .be_i          (be_i),
      .wdata_i       (wdata_i),
      .id_i          (id_i),
      .gnt_o         (gnt_o),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_id_o      (rsp_id_o),
      .rsp_opc_o     (rsp_opc_o),
      .slv_req_o     (slv_req_o),
      .slv_add_o     (slv_add_o),
      .slv_wen_o     (slv_wen_o),
      .slv_be_o      (slv_be_o),
      .slv_wdata_o   (slv_wdata_o),
      .slv_id_o      (slv_id_o),
      .slv_gnt_i     (slv_gnt_i),
      .slv_r_valid_i (slv_r_valid_i),
      .slv_r_rdata_i (slv_r_rdata_i),
      .slv_r_id_i    (slv_r_id_i),
      .slv_r_opc_i   (slv_r_opc_i),
      .err_o         (err_o)
   );

   // Advance one clock; the peripheral answers a grant seen before the edge one cycle later.
   task automatic step();
      logic          g;
      logic [IW-1:0] gid;
      g   = gnt_o;
      gid = slv_id_o;
      @(posedge clk_i);
      #1;
      if (auto_rsp) begin
         slv_r_valid_i = g;
         slv_r_id_i    = g ? gid : '0;
         slv_r_rdata_i = g ? (rdata_mode ? 32'hC0DE0000 + 32'(gid) : fixed_rdata) : '0;
         slv_r_opc_i   = g & rdata_mode & gid[0];
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; req_i = 1'b0; add_i = '0; wen_i = 1'b1; be_i = '1; wdata_i = '0;
      id_i = '0; rsp_ready_i = 1'b1; slv_gnt_i = 1'b1; slv_r_valid_i = 1'b0;
      slv_r_rdata_i = '0; slv_r_id_i = '0; slv_r_opc_i = 1'b0;
      auto_rsp = 1'b1; rdata_mode = 1'b0; fixed_rdata = '0;
      repeat (2) @(posedge clk_i);
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
      n_cmp++; if (rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata_o); end
      n_cmp++; if (rsp_id_o !== 5'd0) begin n_fail++; $display("FAIL reset_id: got %h want 0", rsp_id_o); end
      req_i = 1'b1;
      #1;
      n_cmp++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL reset_credit_gnt: got %b want 1", gnt_o); end
      req_i = 1'b0;
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic test_single_read();
      rsp_ready_i = 1'b1; rdata_mode = 1'b0; fixed_rdata = 32'hDEADBEEF;
      step();
      req_i = 1'b1; wen_i = 1'b1; add_i = 32'h0000_0100; be_i = 4'hF; id_i = 5'd3;
      #1;
      n_cmp++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b want 1", gnt_o); end
      n_cmp++; if (slv_add_o !== 32'h0000_0100) begin n_fail++; $display("FAIL single_add: got %h want 00000100", slv_add_o); end
      n_cmp++; if (slv_id_o !== 5'd3) begin n_fail++; $display("FAIL single_slv_id: got %h want 3", slv_id_o); end
      n_cmp++; if (slv_be_o !== 4'hF) begin n_fail++; $display("FAIL single_be: got %h want f", slv_be_o); end
      step();
      req_i = 1'b0;
      #1;
`ifndef PERIPH_RSP_BYPASS_EN
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_n1_valid: got %b want 0", rsp_valid_o); end
      step();
      #1;
`endif
      n_cmp++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rsp_valid_o); end
      n_cmp++; if (rsp_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h want deadbeef", rsp_rdata_o); end
      n_cmp++; if (rsp_id_o !== 5'd3) begin n_fail++; $display("FAIL single_id: got %h want 3", rsp_id_o); end
      n_cmp++; if (rsp_opc_o !== 1'b0) begin n_fail++; $display("FAIL single_opc: got %b want 0", rsp_opc_o); end
      step();
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_after_valid: got %b want 0", rsp_valid_o); end
      n_cmp++; if (dut.outstanding_q !== 2'd0) begin n_fail++; $display("FAIL single_outstanding: got %0d want 0", dut.outstanding_q); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] gnt_exp;
      logic [15:0] rsp_exp;
      int unsigned next_id = 0;
      int unsigned exp_id  = 0;
`ifdef PERIPH_RSP_BYPASS_EN
      gnt_exp = 16'h00FF;
      rsp_exp = 16'h01FE;
`else
      // Registered credit with DEPTH=2: two grants then one blocked cycle, repeating.
      gnt_exp = 16'h06DB;
      rsp_exp = 16'h1B6C;
`endif
      rsp_ready_i = 1'b1; rdata_mode = 1'b1;
      for (int c = 0; c < 16; c++) begin
         req_i = (next_id < 8); id_i = 5'(next_id); add_i = 32'h200 + 32'(next_id * 4);
         #1;
         n_cmp++; if (gnt_o !== gnt_exp[c]) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b want %b", c, gnt_o, gnt_exp[c]); end
         n_cmp++; if (rsp_valid_o !== rsp_exp[c]) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", c, rsp_valid_o, rsp_exp[c]); end
         if (rsp_exp[c] && rsp_valid_o) begin
            n_cmp++; if (rsp_id_o !== 5'(exp_id)) begin n_fail++; $display("FAIL b2b_id[%0d]: got %0d want %0d", c, rsp_id_o, exp_id); end
            n_cmp++; if (rsp_rdata_o !== 32'hC0DE0000 + exp_id) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", c, rsp_rdata_o, 32'hC0DE0000 + exp_id); end
            n_cmp++; if (rsp_opc_o !== (exp_id % 2 == 1)) begin n_fail++; $display("FAIL b2b_opc[%0d]: got %b want %b", c, rsp_opc_o, exp_id % 2 == 1); end
            exp_id++;
         end
         if (gnt_o && req_i) next_id++;
         step();
      end
      req_i = 1'b0;
      n_cmp++; if (exp_id !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", exp_id); end
   endtask

   task automatic test_backpressure();
      logic [7:0] gnt_exp = 8'h43;
      logic [7:0] rsp_exp = 8'hFC;
      int unsigned next_id = 0;
      rdata_mode = 1'b1;
      for (int c = 0; c < 8; c++) begin
         rsp_ready_i = (c == 5); req_i = 1'b1; id_i = 5'(10 + next_id);
         #1;
         n_cmp++; if (gnt_o !== gnt_exp[c]) begin n_fail++; $display("FAIL bp_gnt[%0d]: got %b want %b", c, gnt_o, gnt_exp[c]); end
         n_cmp++; if (rsp_valid_o !== rsp_exp[c]) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want %b", c, rsp_valid_o, rsp_exp[c]); end
         if (rsp_exp[c] && rsp_valid_o) begin
            n_cmp++; if (rsp_id_o !== ((c < 6) ? 5'd10 : 5'd11)) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d want %0d", c, rsp_id_o, (c < 6) ? 10 : 11); end
         end
         if (gnt_o) next_id++;
         step();
      end
      req_i = 1'b0; rsp_ready_i = 1'b1;
      #1;
      n_cmp++; if (rsp_id_o !== 5'd11 || rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_drain0: got v=%b id=%0d want v=1 id=11", rsp_valid_o, rsp_id_o); end
      step();
      #1;
      n_cmp++; if (rsp_id_o !== 5'd12 || rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_drain1: got v=%b id=%0d want v=1 id=12", rsp_valid_o, rsp_id_o); end
      n_cmp++; if (rsp_rdata_o !== 32'hC0DE000C) begin n_fail++; $display("FAIL bp_drain1_rdata: got %h want c0de000c", rsp_rdata_o); end
      step();
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain2: got %b want 0", rsp_valid_o); end
   endtask

   task automatic test_unexpected();
      auto_rsp = 1'b0; rsp_ready_i = 1'b1; req_i = 1'b0;
      #1;
      n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL unexp_err_before: got %b want 0", err_o); end
      slv_r_valid_i = 1'b1; slv_r_id_i = 5'd7; slv_r_rdata_i = 32'h12345678; slv_r_opc_i = 1'b0;
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL unexp_valid_same: got %b want 0", rsp_valid_o); end
      step();
      slv_r_valid_i = 1'b0;
      #1;
      n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL unexp_err_set: got %b want 1", err_o); end
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL unexp_valid: got %b want 0", rsp_valid_o); end
      repeat (3) step();
      #1;
      n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL unexp_err_sticky: got %b want 1", err_o); end
      n_cmp++; if (dut.outstanding_q !== 2'd0) begin n_fail++; $display("FAIL unexp_outstanding: got %0d want 0", dut.outstanding_q); end
      auto_rsp = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [2:0] gnt_exp = 3'b011;
      rsp_ready_i = 1'b0; rdata_mode = 1'b1; req_i = 1'b1; id_i = 5'd20;
      #1;
      step();
      id_i = 5'd21;
      #1;
      step();
      req_i = 1'b0;
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b want 1", rsp_valid_o); end
      rst_ni = 1'b0;
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", rsp_valid_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b want 0", err_o); end
      auto_rsp = 1'b0; slv_r_valid_i = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
      slv_r_valid_i = 1'b1; slv_r_id_i = 5'd21; slv_r_rdata_i = 32'hC0DE0015;
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_late_valid: got %b want 0", rsp_valid_o); end
      step();
      slv_r_valid_i = 1'b0;
      #1;
      n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL rmid_late_err: got %b want 1", err_o); end
      auto_rsp = 1'b1;
      for (int c = 0; c < 3; c++) begin
         req_i = 1'b1; id_i = 5'(30 + c);
         #1;
         n_cmp++; if (gnt_o !== gnt_exp[c]) begin n_fail++; $display("FAIL rmid_cap[%0d]: got %b want %b", c, gnt_o, gnt_exp[c]); end
         step();
      end
      req_i = 1'b0; rsp_ready_i = 1'b1;
      repeat (4) step();
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_drained: got %b want 0", rsp_valid_o); end
   endtask

`ifdef PERIPH_RSP_BYPASS_EN
   task automatic test_bypass();
      rsp_ready_i = 1'b1; rdata_mode = 1'b0; fixed_rdata = 32'hCAFEF00D;
      req_i = 1'b1; id_i = 5'd9;
      #1;
      step();
      req_i = 1'b0;
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL byp_valid: got %b want 1", rsp_valid_o); end
      n_cmp++; if (rsp_rdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL byp_rdata: got %h want cafef00d", rsp_rdata_o); end
      n_cmp++; if (rsp_id_o !== 5'd9) begin n_fail++; $display("FAIL byp_id: got %0d want 9", rsp_id_o); end
      step();
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL byp_after: got %b want 0", rsp_valid_o); end
      rsp_ready_i = 1'b0; req_i = 1'b1; id_i = 5'd10;
      #1;
      step();
      req_i = 1'b0;
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL byp_nr_same: got %b want 0", rsp_valid_o); end
      step();
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 5'd10) begin n_fail++; $display("FAIL byp_nr_next: got v=%b id=%0d want v=1 id=10", rsp_valid_o, rsp_id_o); end
      rsp_ready_i = 1'b1;
      step();
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL byp_nr_drain: got %b want 0", rsp_valid_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_read();
      test_back_to_back();
      test_backpressure();
      test_unexpected();
      test_reset_mid();
`ifdef PERIPH_RSP_BYPASS_EN
      test_bypass();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
